instruction_encode: RTL and testbench

- Encoder counterpart of the RV32I instruction decoder: accepts instruction fields (format, registers, funct bits, immediate) over a valid/ready handshake.
- Range-checks the immediate, packs a 32-bit RV32I word, and emits it with a sequential instruction-memory write address.
- Used by the boot/test loader to fill instruction memory before the core runs. Its output is what the decoder later consumes.

---
 rtl/rv32i_pkg.sv | 52 +++++
 rtl/instruction_encode_if.sv | 29 ++
 rtl/instruction_encode_immediate.sv | 83 ++++++++
 rtl/instruction_encode.sv | 94 +++++++++
 tb/tb_instruction_encode.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// RV32I encoding constants and format descriptors shared by the encoder and decoder.
package rv32i_pkg;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE_ALU  = 7'b0010011;
  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] I_TYPE_JALR = 7'b1100111;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] B_TYPE      = 7'b1100011;
  localparam logic [6:0] JAL         = 7'b1101111;
  localparam logic [6:0] LUI         = 7'b0110111;
  localparam logic [6:0] AUIPC       = 7'b0010111;

  typedef enum logic [3:0] {
    FMT_R, FMT_I_ALU, FMT_I_LOAD, FMT_I_JALR, FMT_S, FMT_B, FMT_JAL, FMT_LUI, FMT_AUIPC
  } instr_fmt_t;

  localparam logic [2:0] F3_BEQ  = 3'b000, F3_BNE  = 3'b001, F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB   = 3'b000, F3_LH   = 3'b001, F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100, F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000, F3_SH   = 3'b001, F3_SW   = 3'b010;
  localparam logic [2:0] F3_SLLI = 3'b001, F3_SRXI = 3'b101;

  // Which register/funct3 fields a format carries, plus its opcode.
  typedef struct packed {
    logic [6:0] opcode;
    logic       has_rd;
    logic       has_funct3;
    logic       has_rs1;
    logic       has_rs2;
  } fmt_fields_t;

  function automatic fmt_fields_t fmt_fields(instr_fmt_t fmt);
    fmt_fields_t f;
    f = '0;
    case (fmt)
      FMT_R:      f = '{R_TYPE,      1'b1, 1'b1, 1'b1, 1'b1};
      FMT_I_ALU:  f = '{I_TYPE_ALU,  1'b1, 1'b1, 1'b1, 1'b0};
      FMT_I_LOAD: f = '{I_TYPE_LOAD, 1'b1, 1'b1, 1'b1, 1'b0};
      FMT_I_JALR: f = '{I_TYPE_JALR, 1'b1, 1'b1, 1'b1, 1'b0};
      FMT_S:      f = '{S_TYPE,      1'b0, 1'b1, 1'b1, 1'b1};
      FMT_B:      f = '{B_TYPE,      1'b0, 1'b1, 1'b1, 1'b1};
      FMT_JAL:    f = '{JAL,         1'b1, 1'b0, 1'b0, 1'b0};
      FMT_LUI:    f = '{LUI,         1'b1, 1'b0, 1'b0, 1'b0};
      FMT_AUIPC:  f = '{AUIPC,       1'b1, 1'b0, 1'b0, 1'b0};
      default:    f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instruction_encode_if.sv
// Field-bundle input channel and encoded-word output channel of the instruction encoder.
interface instruction_encode_if import rv32i_pkg::*; #(parameter int XLEN = 32);

  logic             in_valid;
  logic             in_ready;
  instr_fmt_t       fmt;
  logic [2:0]       funct3;
  logic             alt;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [XLEN-1:0]  imm;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_addr;
  logic [31:0]      out_word;

  modport master (
    output in_valid, fmt, funct3, alt, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_addr, out_word
  );

  modport slave (
    input  in_valid, fmt, funct3, alt, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_addr, out_word
  );

endinterface

// File: rtl/instruction_encode_immediate.sv
// Places the immediate (and funct7 alt bit) into RV32I word positions and flags
// bundles whose immediate, funct3 or format cannot be encoded.
module immediate_encode import rv32i_pkg::*; #(
  parameter int XLEN = 32
) (
  input  instr_fmt_t       fmt,
  input  logic [2:0]       funct3,
  input  logic             alt,
  input  logic [XLEN-1:0]  imm,
  output logic [31:0]      imm_bits,
  output logic             illegal
);

  localparam logic signed [XLEN-1:0] I_MIN = XLEN'(-2048);
  localparam logic signed [XLEN-1:0] I_MAX = XLEN'(2047);
  localparam logic signed [XLEN-1:0] B_MIN = XLEN'(-4096);
  localparam logic signed [XLEN-1:0] B_MAX = XLEN'(4094);
  localparam logic signed [XLEN-1:0] J_MIN = XLEN'(-1048576);
  localparam logic signed [XLEN-1:0] J_MAX = XLEN'(1048574);

  logic signed [XLEN-1:0] simm;
  logic fits_i, fits_b, fits_j, shamt_ok, load_f3_ok;

  assign simm       = $signed(imm);
  assign fits_i     = (simm >= I_MIN) && (simm <= I_MAX);
  assign fits_b     = (simm >= B_MIN) && (simm <= B_MAX) && !imm[0];
  assign fits_j     = (simm >= J_MIN) && (simm <= J_MAX) && !imm[0];
  assign shamt_ok   = (imm[XLEN-1:5] == '0);
  assign load_f3_ok = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

  // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
  always_comb begin
    imm_bits = '0;
    illegal  = 1'b0;
    case (fmt)
      FMT_R: imm_bits[30] = alt;
      FMT_I_ALU: begin
        if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
          imm_bits[24:20] = imm[4:0];
          imm_bits[30]    = (funct3 == F3_SRXI) && alt;
          illegal         = !shamt_ok || (funct3 == F3_SLLI && alt);
        end else begin
          imm_bits[31:20] = imm[11:0];
          illegal         = !fits_i;
        end
      end
      FMT_I_LOAD: begin
        imm_bits[31:20] = imm[11:0];
        illegal         = !fits_i || !load_f3_ok;
      end
      FMT_I_JALR: begin
        imm_bits[31:20] = imm[11:0];
        illegal         = !fits_i;
      end
      FMT_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        illegal         = !fits_i || !(funct3 inside {F3_SB, F3_SH, F3_SW});
      end
      FMT_B: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        illegal         = !fits_b ||
                          !(funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
      end
      FMT_JAL: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        illegal         = !fits_j;
      end
      FMT_LUI, FMT_AUIPC: begin
        imm_bits[31:12] = imm[31:12];
        illegal         = (imm[11:0] != '0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_encode.sv
// RV32I instruction encoder: accepts field bundles, emits packed words with
// sequential instruction-memory addresses through a single output register.
module instruction_encode import rv32i_pkg::*; #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int              DEPTH     = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  instruction_encode_if.slave  bus,
  output logic                 full,
  output logic                 error
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("BASE_ADDR must be 4-byte aligned");
  end

  logic [CNT_W-1:0] count;
  logic             out_valid_q;
  logic [31:0]      out_word_q;
  logic [XLEN-1:0]  out_addr_q;
  logic             error_q;
  logic [31:0]      imm_bits;
  logic [31:0]      word;
  logic             illegal;
  logic             accept;
  logic             out_fire;
  fmt_fields_t      fields;

  immediate_encode #(.XLEN(XLEN)) u_imm (
    .fmt      (bus.fmt),
    .funct3   (bus.funct3),
    .alt      (bus.alt),
    .imm      (bus.imm),
    .imm_bits (imm_bits),
    .illegal  (illegal)
  );

  always_comb begin
    fields = fmt_fields(bus.fmt);
    word   = imm_bits;
    word[6:0] = fields.opcode;
    if (fields.has_rd)     word[11:7]  = bus.rd;
    if (fields.has_funct3) word[14:12] = bus.funct3;
    if (fields.has_rs1)    word[19:15] = bus.rs1;
    if (fields.has_rs2)    word[24:20] = bus.rs2;
  end

  assign full         = (count == CNT_W'(DEPTH));
  assign bus.in_ready = reset_n && !clear && !full && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid_q && bus.out_ready;

  // out_addr_q always holds the address of the current (or next) word, so it
  // advances on every output handshake and a new word simply inherits it.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= BASE_ADDR;
      count       <= '0;
      error_q     <= 1'b0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      count       <= '0;
      error_q     <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid_q <= 1'b0;
        out_addr_q  <= out_addr_q + XLEN'(4);
      end
      if (accept && !illegal) begin
        out_valid_q <= 1'b1;
        out_word_q  <= word;
        count       <= count + 1'b1;
      end
      if (accept && illegal) begin
        error_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_addr  = out_addr_q;
  assign error         = error_q;

endmodule

// File: tb/tb_instruction_encode.sv
// Self-checking bench: directed RV32I encodings plus randomized bundles against a
// cycle-level reference model built from the encoding and legality rules.
module tb_instruction_encode;
  import rv32i_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic clear;
  logic full;
  logic error;

  instruction_encode_if #(.XLEN(32)) bus ();

  instruction_encode #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus),
    .full    (full),
    .error   (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_pend;
  logic [31:0] m_word;
  int          m_emitted;
  int          m_accepted;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_full();
    return m_accepted == DEPTH;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_word = '0; m_emitted = 0; m_accepted = 0; m_err = 0;
  endtask

  function automatic void ref_encode(input instr_fmt_t f, input logic [2:0] f3, input logic alt,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] imm,
                                     output bit legal, output logic [31:0] w);
    int s;
    logic [31:0] d, t3, a, b;
    bit fits_i;
    s = $signed(imm);
    d  = 32'(rd)  << 7;
    t3 = 32'(f3)  << 12;
    a  = 32'(rs1) << 15;
    b  = 32'(rs2) << 20;
    fits_i = (s >= -2048) && (s <= 2047);
    legal = 1;
    w = '0;
    case (f)
      FMT_R: w = (alt ? 32'h4000_0000 : 32'h0) | b | a | t3 | d | 32'h33;
      FMT_I_ALU:
        if (f3 == 3'd1 || f3 == 3'd5) begin
          legal = (imm < 32'd32) && !(f3 == 3'd1 && alt);
          w = ((f3 == 3'd5 && alt) ? 32'h4000_0000 : 32'h0) | ((imm & 32'h1F) << 20)
              | a | t3 | d | 32'h13;
        end else begin
          legal = fits_i;
          w = ((imm & 32'hFFF) << 20) | a | t3 | d | 32'h13;
        end
      FMT_I_LOAD: begin
        legal = fits_i && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        w = ((imm & 32'hFFF) << 20) | a | t3 | d | 32'h03;
      end
      FMT_I_JALR: begin
        legal = fits_i;
        w = ((imm & 32'hFFF) << 20) | a | t3 | d | 32'h67;
      end
      FMT_S: begin
        legal = fits_i && (f3 <= 3'd2);
        w = (((imm >> 5) & 32'h7F) << 25) | b | a | t3 | ((imm & 32'h1F) << 7) | 32'h23;
      end
      FMT_B: begin
        legal = (s >= -4096) && (s <= 4094) && (imm % 2 == 0) && !(f3 inside {3'd2, 3'd3});
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | b | a | t3
            | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      end
      FMT_JAL: begin
        legal = (s >= -1048576) && (s <= 1048574) && (imm % 2 == 0);
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
      end
      FMT_LUI: begin
        legal = (imm & 32'hFFF) == 0;
        w = (imm & 32'hFFFF_F000) | d | 32'h37;
      end
      FMT_AUIPC: begin
        legal = (imm & 32'hFFF) == 0;
        w = (imm & 32'hFFFF_F000) | d | 32'h17;
      end
      default: legal = 0;
    endcase
  endfunction

  task automatic drive(input logic v, input instr_fmt_t f, input logic [2:0] f3, input logic a,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] i, input logic ordy, input logic clr);
    bus.in_valid = v; bus.fmt = f; bus.funct3 = f3; bus.alt = a;
    bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = i;
    bus.out_ready = ordy; clear = clr;
  endtask

  task automatic idle(input logic ordy, input logic clr);
    drive(1'b0, FMT_R, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, ordy, clr);
  endtask

  // Called at a falling edge with inputs applied; leaves at the next falling edge.
  task automatic step();
    bit rdy, legal;
    logic [31:0] w;
    #1;
    rdy = !m_full() && !clear && (!m_pend || bus.out_ready);
    check("in_ready", 32'(bus.in_ready), 32'(rdy));
    ref_encode(bus.fmt, bus.funct3, bus.alt, bus.rd, bus.rs1, bus.rs2, bus.imm, legal, w);
    if (clear) begin
      model_reset();
    end else begin
      if (m_pend && bus.out_ready) begin m_pend = 0; m_emitted++; end
      if (bus.in_valid && rdy) begin
        if (legal) begin m_pend = 1; m_word = w; m_accepted++; end
        else m_err = 1;
      end
    end
    @(posedge clk); #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_pend));
    check("out_addr", bus.out_addr, BASE + 32'(4 * m_emitted));
    check("full", 32'(full), 32'(m_full()));
    check("error", 32'(error), 32'(m_err));
    if (m_pend) check("out_word", bus.out_word, m_word);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_imm();
    int bnd [16] = '{-2048, 2047, -2049, 2048, -4096, 4094, -4098, 4096, 4095,
                     -1048576, 1048574, 1048576, -1048578, 31, 32, 1};
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 4095)) - 32'd2048;
      1: return 32'(bnd[$urandom_range(0, 15)]);
      2: return $urandom();
      3: return $urandom() & 32'hFFFF_F000;
      4: return 32'($urandom_range(0, 2097151)) - 32'h0010_0000;
      default: return 32'($urandom_range(0, 40));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    idle(1'b1, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_word", bus.out_word, 32'd0);
    check("rst_out_addr", bus.out_addr, BASE);
    check("rst_full", 32'(full), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b1;

    // Basic encodings with consecutive addresses
    drive(1'b1, FMT_I_ALU, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0); step();
    check("addi_word", bus.out_word, 32'h0050_0093);
    check("addi_addr", bus.out_addr, BASE);
    drive(1'b1, FMT_R, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0); step();
    check("add_word", bus.out_word, 32'h0020_81B3);
    check("add_addr", bus.out_addr, BASE + 32'd4);
    drive(1'b1, FMT_R, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0); step();
    check("sub_word", bus.out_word, 32'h4020_81B3);
    check("sub_addr", bus.out_addr, BASE + 32'd8);
    idle(1'b1, 1'b0); step();
    idle(1'b1, 1'b1); step();

    drive(1'b1, FMT_S, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 1'b0); step();
    check("sw_word", bus.out_word, 32'h0020_A423);
    drive(1'b1, FMT_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 1'b0); step();
    check("beq_word", bus.out_word, 32'hFE20_8EE3);
    drive(1'b1, FMT_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 1'b0); step();
    check("jal_word", bus.out_word, 32'h0080_00EF);
    drive(1'b1, FMT_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 1'b0); step();
    check("lui_word", bus.out_word, 32'h1234_52B7);
    idle(1'b1, 1'b0); step();
    check("full_after_depth", 32'(full), 32'd1);
    idle(1'b1, 1'b1); step();

    // Illegal immediates are consumed without output
    drive(1'b1, FMT_I_ALU, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 1'b0); step();
    check("ill_addi_valid", 32'(bus.out_valid), 32'd0);
    check("ill_addi_error", 32'(error), 32'd1);
    drive(1'b1, FMT_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1, 1'b0); step();
    drive(1'b1, FMT_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b1, 1'b0); step();
    check("ill_addr_kept", bus.out_addr, BASE);
    idle(1'b1, 1'b0); step();
    check("ill_error_sticky", 32'(error), 32'd1);
    idle(1'b1, 1'b1); step();
    check("clear_error", 32'(error), 32'd0);

    // Backpressure: pending word holds, next bundle waits
    drive(1'b1, FMT_I_ALU, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0, 1'b0); step();
    drive(1'b1, FMT_I_ALU, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd9, 1'b0, 1'b0);
    repeat (3) begin
      step();
      check("bp_hold_word", bus.out_word, 32'h0070_0093);
    end
    bus.out_ready = 1'b1; step();
    check("bp_next_word", bus.out_word, 32'h0090_0093);
    check("bp_next_addr", bus.out_addr, BASE + 32'd4);
    idle(1'b1, 1'b0); step();

    // Fill to DEPTH, fifth bundle refused
    idle(1'b1, 1'b1); step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, FMT_I_ALU, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b1, 1'b0); step();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_addr", bus.out_addr, BASE + 32'd16);
    idle(1'b1, 1'b1); step();
    drive(1'b1, FMT_I_ALU, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd1, 1'b0, 1'b0); step();
    check("after_clear_addr", bus.out_addr, BASE);

    // Asynchronous reset with a word pending
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check("arst_out_addr", bus.out_addr, BASE);
    model_reset();
    @(negedge clk);
    idle(1'b1, 1'b0);
    reset_n = 1'b1;
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      drive(1'($urandom_range(0, 9) < 8), instr_fmt_t'(4'($urandom_range(0, 10))),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rand_imm(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
